// File: rtl/hedios_rx_deframer.sv
// hedios_rx_deframer: assembles 1+4 byte Hedios packets from a UART byte stream into a show-ahead FIFO
// Ports: clk/rst (sync, active high); byte_valid/byte_data/byte_frame_err from the UART receiver;
//        pop_packet/packet_command/packet_data/queue_empty/queue_full/lost_data to the controller;
//        frame_drop_count counts discarded partial frames (saturating).
// Option: define HEDIOS_RX_CHECKSUM_EN for 6-byte frames whose last byte is the XOR of bytes 0..4.
module hedios_rx_deframer #(
  parameter int CLK_RATE       = 100_000_000,
  parameter int FIFO_DEPTH     = 16,
  parameter int TIMEOUT_CYCLES = 2000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  input  logic        byte_frame_err,
  input  logic        pop_packet,
  output logic [7:0]  packet_command,
  output logic [31:0] packet_data,
  output logic        queue_empty,
  output logic        queue_full,
  output logic        lost_data,
  output logic [7:0]  frame_drop_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES - 1);
`ifdef HEDIOS_RX_CHECKSUM_EN
  localparam logic [2:0] LAST = 3'd5;
`else
  localparam logic [2:0] LAST = 3'd4;
`endif

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1 || CLK_RATE < 1) begin : g_bad_params
    $error("hedios_rx_deframer: illegal parameters");
  end

  typedef enum logic [1:0] {IDLE, COLLECT, COMMIT} state_t;

  state_t          r_state, w_next;
  logic [2:0]      r_idx;
  logic [TW-1:0]   r_tmo;
  logic [7:0]      r_cmd;
  logic [31:0]     r_data;
  logic [7:0]      r_drops;
  logic [39:0]     r_mem [FIFO_DEPTH];
  logic [39:0]     r_head;
  logic [AW-1:0]   r_wp, r_rp;
  logic [CW-1:0]   r_cnt;
  logic            r_lost;
  logic            w_good, w_bad, w_tmo, w_chk_ok;
  logic            w_load, w_shift, w_drop;
  logic            w_commit, w_pop, w_full, w_wr;
  logic [39:0]     w_pkt;
  logic [AW-1:0]   w_rp_nx;

  assign w_good = byte_valid && !byte_frame_err;
  assign w_bad  = byte_valid && byte_frame_err;
  assign w_tmo  = !byte_valid && r_tmo == TMO_MAX;

`ifdef HEDIOS_RX_CHECKSUM_EN
  logic [7:0] r_chk;
  assign w_chk_ok = r_idx != LAST || byte_data == r_chk;
  always_ff @(posedge clk)
    r_chk <= rst ? 8'd0 : w_load ? byte_data : w_shift ? r_chk ^ byte_data : r_chk;
`else
  assign w_chk_ok = 1'b1;
`endif

  always_comb begin
    w_next  = r_state;
    w_load  = 1'b0;
    w_shift = 1'b0;
    w_drop  = 1'b0;
    if (r_state == COLLECT) begin
      if (w_bad || w_tmo) begin
        w_next = IDLE;
        w_drop = 1'b1;
      end else if (w_good) begin
        w_shift = r_idx <= 3'd4;
        w_next  = r_idx != LAST ? COLLECT : w_chk_ok ? COMMIT : IDLE;
        w_drop  = !w_chk_ok;
      end
    end else begin
      // COMMIT behaves like IDLE on input so a byte arriving during the write starts the next frame
      w_load = w_good;
      w_next = w_good ? COLLECT : IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_idx   <= 3'd0;
      r_tmo   <= '0;
      r_cmd   <= 8'd0;
      r_data  <= 32'd0;
      r_drops <= 8'd0;
    end else begin
      r_state <= w_next;
      r_idx   <= w_load ? 3'd1 : w_shift ? r_idx + 3'd1 : r_idx;
      r_cmd   <= w_load ? byte_data : r_cmd;
      r_data  <= w_shift ? {r_data[23:0], byte_data} : r_data;
      r_tmo   <= (r_state == COLLECT && !byte_valid) ? r_tmo + TW'(1) : '0;
      r_drops <= (w_drop && r_drops != 8'hFF) ? r_drops + 8'd1 : r_drops;
    end
  end

  assign w_commit = r_state == COMMIT;
  assign w_pop    = pop_packet && r_cnt != '0;
  assign w_full   = r_cnt == FULL;
  assign w_wr     = w_commit && (!w_full || w_pop);
  assign w_pkt    = {r_cmd, r_data};
  assign w_rp_nx  = r_rp + AW'(1);

  always_ff @(posedge clk)
    if (w_wr) r_mem[r_wp] <= w_pkt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp   <= '0;
      r_rp   <= '0;
      r_cnt  <= '0;
      r_lost <= 1'b0;
      r_head <= 40'd0;
    end else begin
      r_wp   <= w_wr ? r_wp + AW'(1) : r_wp;
      r_rp   <= w_pop ? w_rp_nx : r_rp;
      r_cnt  <= r_cnt + CW'(w_wr) - CW'(w_pop);
      r_lost <= r_lost || (w_commit && !w_wr);
      // head tracks the packet that will be at the read pointer after this cycle
      r_head <= (w_wr && (r_cnt == '0 || (w_pop && r_cnt == CW'(1)))) ? w_pkt :
                (w_pop && r_cnt != CW'(1)) ? r_mem[w_rp_nx] : r_head;
    end
  end

  assign packet_command   = r_head[39:32];
  assign packet_data      = r_head[31:0];
  assign queue_empty      = r_cnt == '0;
  assign queue_full       = w_full;
  assign lost_data        = r_lost;
  assign frame_drop_count = r_drops;
endmodule

// File: tb/tb_hedios_rx_deframer.sv
// tb_hedios_rx_deframer: directed self-checking bench for hedios_rx_deframer
module tb_hedios_rx_deframer;
  localparam int TMO = 2000;
  localparam int DEPTH = 16;
`ifdef HEDIOS_RX_CHECKSUM_EN
  localparam int LEN = 6;
`else
  localparam int LEN = 5;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'd0;
  logic        byte_frame_err = 1'b0;
  logic        pop_packet = 1'b0;
  logic [7:0]  packet_command;
  logic [31:0] packet_data;
  logic        queue_empty, queue_full, lost_data;
  logic [7:0]  frame_drop_count;
  int          n_tests = 0;
  int          n_fail = 0;

  hedios_rx_deframer #(.CLK_RATE(100_000_000), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_frame_err(byte_frame_err), .pop_packet(pop_packet),
    .packet_command(packet_command), .packet_data(packet_data),
    .queue_empty(queue_empty), .queue_full(queue_full), .lost_data(lost_data),
    .frame_drop_count(frame_drop_count)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick;
    tick;
    rst = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic err);
    byte_valid = 1'b1;
    byte_data = b;
    byte_frame_err = err;
    tick;
    byte_valid = 1'b0;
    byte_frame_err = 1'b0;
  endtask

  task automatic put_frame(input logic [7:0] c, input logic [31:0] d, input logic pop_first, input int gap);
    logic [7:0] b [6];
    b[0] = c;
    b[1] = d[31:24];
    b[2] = d[23:16];
    b[3] = d[15:8];
    b[4] = d[7:0];
    b[5] = c ^ d[31:24] ^ d[23:16] ^ d[15:8] ^ d[7:0];
    for (int k = 0; k < LEN; k++) begin
      byte_valid = 1'b1;
      byte_data = b[k];
      pop_packet = pop_first && k == 0;
      tick;
      byte_valid = 1'b0;
      pop_packet = 1'b0;
      if (k < LEN - 1) repeat (gap) tick;
    end
  endtask

  task automatic pop_one;
    pop_packet = 1'b1;
    tick;
    pop_packet = 1'b0;
  endtask

  initial begin
    tick;
    tick;
    check("rst_empty", 32'(queue_empty), 32'd1);
    check("rst_full", 32'(queue_full), 32'd0);
    check("rst_lost", 32'(lost_data), 32'd0);
    check("rst_drops", 32'(frame_drop_count), 32'd0);
    check("rst_cmd", 32'(packet_command), 32'd0);
    check("rst_data", packet_data, 32'd0);
    rst = 1'b0;
    tick;

    put_frame(8'h12, 32'hDEADBEEF, 1'b0, 9);
    check("t1_empty_n1", 32'(queue_empty), 32'd1);
    tick;
    check("t1_empty_n2", 32'(queue_empty), 32'd0);
    check("t1_cmd", 32'(packet_command), 32'h12);
    check("t1_data", packet_data, 32'hDEADBEEF);
    pop_one;
    check("t1_pop_empty", 32'(queue_empty), 32'd1);
    pop_one;
    check("t1_pop_empty_again", 32'(queue_empty), 32'd1);
    check("t1_pop_empty_full", 32'(queue_full), 32'd0);

    do_reset;
    send_byte(8'h01, 1'b0);
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    repeat (TMO + 5) tick;
    check("t2_drops", 32'(frame_drop_count), 32'd1);
    check("t2_empty_after_tmo", 32'(queue_empty), 32'd1);
    put_frame(8'h02, 32'h00000007, 1'b0, 0);
    tick;
    check("t2_cmd", 32'(packet_command), 32'h02);
    check("t2_data", packet_data, 32'h00000007);
    pop_one;
    check("t2_one_packet", 32'(queue_empty), 32'd1);

    do_reset;
    send_byte(8'h07, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b1);
    put_frame(8'h05, 32'h11223344, 1'b0, 0);
    tick;
    check("t3_drops", 32'(frame_drop_count), 32'd1);
    check("t3_cmd", 32'(packet_command), 32'h05);
    check("t3_data", packet_data, 32'h11223344);
    send_byte(8'h09, 1'b1);
    check("t3_idle_err_nocount", 32'(frame_drop_count), 32'd1);
    for (int i = 0; i < 260; i++) begin
      send_byte(8'h01, 1'b0);
      send_byte(8'h00, 1'b1);
    end
    check("t3_drops_sat", 32'(frame_drop_count), 32'd255);

    do_reset;
    for (int i = 1; i <= DEPTH + 1; i++) begin
      put_frame(8'(i), 32'h01010101 * i, 1'b0, 0);
      tick;
      if (i == DEPTH) begin
        check("t4_full16", 32'(queue_full), 32'd1);
        check("t4_nolost16", 32'(lost_data), 32'd0);
      end
    end
    check("t4_lost17", 32'(lost_data), 32'd1);
    check("t4_full17", 32'(queue_full), 32'd1);
    for (int i = 1; i <= DEPTH; i++) begin
      check($sformatf("t4_cmd%0d", i), 32'(packet_command), 32'(i));
      check($sformatf("t4_data%0d", i), packet_data, 32'h01010101 * i);
      pop_one;
    end
    check("t4_empty", 32'(queue_empty), 32'd1);
    check("t4_lost_sticky", 32'(lost_data), 32'd1);
    do_reset;
    check("t4_lost_cleared", 32'(lost_data), 32'd0);

    for (int i = 1; i <= DEPTH; i++) put_frame(8'(i), 32'h01010101 * i, 1'b0, 0);
    tick;
    check("t5_full", 32'(queue_full), 32'd1);
    for (int i = DEPTH + 1; i <= DEPTH + 4; i++) put_frame(8'(i), 32'h01010101 * i, i > DEPTH + 1, 0);
    pop_one;
    check("t5_full_held", 32'(queue_full), 32'd1);
    check("t5_nolost", 32'(lost_data), 32'd0);
    check("t5_head_cmd", 32'(packet_command), 32'd5);
    check("t5_head_data", packet_data, 32'h05050505);

    do_reset;
    for (int i = 1; i <= 3; i++) begin
      put_frame(8'(i + 8'h40), 32'h10203040 + 32'(i), 1'b0, 0);
      tick;
    end
    send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b1);
    check("t6_queued", 32'(queue_empty), 32'd0);
    check("t6_drops_pre", 32'(frame_drop_count), 32'd1);
    send_byte(8'h55, 1'b0);
    send_byte(8'h66, 1'b0);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("t6_empty", 32'(queue_empty), 32'd1);
    check("t6_drops", 32'(frame_drop_count), 32'd0);
    check("t6_lost", 32'(lost_data), 32'd0);
    check("t6_cmd", 32'(packet_command), 32'd0);
    put_frame(8'h3C, 32'hCAFEF00D, 1'b0, 2);
    tick;
    check("t6_new_cmd", 32'(packet_command), 32'h3C);
    check("t6_new_data", packet_data, 32'hCAFEF00D);
    check("t6_new_drops", 32'(frame_drop_count), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
